// File: rtl/apb_uart_rx.sv
// APB slave UART receiver: 2-flop rx synchronizer, free-running 16x baud
// tick, 8N1 receive FSM, small RX FIFO and status/control registers.
//
// state | meaning
// IDLE  | waiting for a falling edge on synchronized rx (receiver enabled)
// START | counting to mid start bit to confirm it is a real start bit
// DATA  | sampling 8 data bits, LSB first, once per 16 ticks
// STOP  | sampling the stop bit, then push byte or flag framing error
module apb_uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [4:0]  PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic        rx
);

    localparam int DIV = CLK_FREQ / BAUD_RATE / 16;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    rx_state_t   state;
    logic        rx_meta, rx_s;
    logic [DW-1:0] baud_cnt;
    logic        tick;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        push_pulse, ferr_pulse;

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, push, pop, ovr_set;

    logic        rx_enable, overrun, frame_err;
    logic        apb_rd, apb_wr;
    logic [2:0]  reg_sel;
    logic        unused_bits;

    assign apb_rd  = PSEL & PENABLE & ~PWRITE;
    assign apb_wr  = PSEL & PENABLE & PWRITE;
    assign reg_sel = PADDR[4:2];
    assign PREADY  = PSEL & PENABLE;
    assign unused_bits = ^{PADDR[1:0], PWDATA[31:4], PWDATA[1]};

    // Two-flop synchronizer; idle-high line, so reset to 1 to avoid a fake start.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Free-running down-counter; tick fires on terminal count 0 every DIV cycles.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            baud_cnt <= '0;
        else if (baud_cnt == '0)
            baud_cnt <= DIV_LAST;
        else
            baud_cnt <= baud_cnt - 1'b1;
    end

    assign tick = (baud_cnt == '0);

    // Receive FSM; emits one-cycle push/frame-error pulses after the stop sample.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            push_pulse <= 1'b0;
            ferr_pulse <= 1'b0;
        end else begin
            push_pulse <= 1'b0;
            ferr_pulse <= 1'b0;
            if (!rx_enable) begin
                state    <= IDLE;
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                        end
                    end
                    START: begin
                        if (tick) begin
                            if (tick_cnt == 4'd7) begin
                                if (!rx_s) begin
                                    state    <= DATA;
                                    tick_cnt <= '0;
                                    bit_cnt  <= '0;
                                end else begin
                                    state <= IDLE;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            if (tick_cnt == 4'd15) begin
                                shift_reg <= {rx_s, shift_reg[7:1]};
                                tick_cnt  <= '0;
                                if (bit_cnt == 3'd7)
                                    state <= STOP;
                                else
                                    bit_cnt <= bit_cnt + 1'b1;
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    STOP: begin
                        if (tick) begin
                            if (tick_cnt == 4'd15) begin
                                if (rx_s)
                                    push_pulse <= 1'b1;
                                else
                                    ferr_pulse <= 1'b1;
                                state    <= IDLE;
                                tick_cnt <= '0;
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = apb_rd && (reg_sel == 3'd1) && !empty;
    assign push    = push_pulse && (!full || pop);
    assign ovr_set = push_pulse && full && !pop;

    // FIFO pointers carry one extra bit to tell full from empty.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge PCLK) begin
        if (push)
            fifo_mem[wr_ptr[AW-1:0]] <= shift_reg;
    end

    // Sticky flags (set wins over write-1-to-clear) and the enable bit.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rx_enable <= 1'b0;
        end else begin
            overrun   <= ovr_set
                       | (overrun & ~(apb_wr && (reg_sel == 3'd0) && PWDATA[2]));
            frame_err <= ferr_pulse
                       | (frame_err & ~(apb_wr && (reg_sel == 3'd0) && PWDATA[3]));
            if (apb_wr && (reg_sel == 3'd2))
                rx_enable <= PWDATA[0];
        end
    end

    // Read mux; zero outside a read access phase and for unmapped addresses.
    always_comb begin
        PRDATA = '0;
        if (apb_rd) begin
            case (reg_sel)
                3'd0: PRDATA = {28'd0, frame_err, overrun, full, empty};
                3'd1: if (!empty) PRDATA = {24'd0, fifo_mem[rd_ptr[AW-1:0]]};
                3'd2: PRDATA = {31'd0, rx_enable};
                default: PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_rx.sv
// Randomized bench for apb_uart_rx against a queue-based receive model.
// Runs at a reduced clock so one bit is 64 PCLK (tick every 4 PCLK).
module tb_apb_uart_rx;

    localparam int CLK_FREQ  = 7_372_800;
    localparam int BAUD_RATE = 115200;
    localparam int DEPTH     = 4;
    localparam int BIT_CYC   = 64;

    logic        PCLK, PRESET;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PENABLE, PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        rx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    bit m_ovr, m_fe, m_en;

    apb_uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PWRITE (PWRITE),
        .PENABLE(PENABLE),
        .PSEL   (PSEL),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .rx     (rx)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_usr();
        return {28'd0, m_fe, m_ovr, (exp_q.size() == DEPTH), (exp_q.size() == 0)};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        m_en  = 1'b0;
    endtask

    task automatic clk(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        clk(1);
        PENABLE = 1'b1;
        clk(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        clk(1);
        PENABLE = 1'b1;
        #1;
        d = PRDATA;
        clk(1);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic check_usr(input string tag);
        logic [31:0] d;
        apb_read(5'h00, d);
        check_eq(tag, d, model_usr());
    endtask

    task automatic read_rdr(input string tag);
        logic [31:0] d, e;
        apb_read(5'h04, d);
        e = (exp_q.size() > 0) ? {24'd0, exp_q.pop_front()} : 32'd0;
        check_eq(tag, d, e);
    endtask

    task automatic write_usr(input logic [31:0] v);
        apb_write(5'h00, v);
        if (v[2]) m_ovr = 1'b0;
        if (v[3]) m_fe  = 1'b0;
    endtask

    task automatic set_en(input bit en);
        apb_write(5'h08, {31'd0, en});
        m_en = en;
    endtask

    // Frames start on a cycle count that is a multiple of 4 so the tick
    // phase relative to the start bit is the same for every frame.
    task automatic align4();
        while (cyc % 4 != 0) clk(1);
    endtask

    // 8N1 frame. A bad stop bit is held low past the sample point only, so
    // its tail is not mistaken for a new start bit. rst_bit pulses PRESET
    // in the middle of that data bit.
    task automatic send_frame(input logic [7:0] b, input bit good_stop, input int rst_bit);
        align4();
        rx = 1'b0;
        clk(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == rst_bit) begin
                clk(20);
                PRESET = 1'b1;
                clk(3);
                PRESET = 1'b0;
                model_reset();
                clk(BIT_CYC - 23);
            end else begin
                clk(BIT_CYC);
            end
        end
        if (good_stop) begin
            rx = 1'b1;
            clk(BIT_CYC);
        end else begin
            rx = 1'b0;
            clk(40);
            rx = 1'b1;
            clk(BIT_CYC - 40);
        end
        clk(16);
        if (m_en) begin
            if (!good_stop)
                m_fe = 1'b1;
            else if (exp_q.size() < DEPTH)
                exp_q.push_back(b);
            else
                m_ovr = 1'b1;
        end
    endtask

    // Holds a continuous USR read and reports the edge where empty drops.
    task automatic poll_push(input int c0, output int off);
        off = -1;
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = 5'h00; PENABLE = 1'b1;
        for (int i = 0; i < 800; i++) begin
            clk(1);
            if (PRDATA[0] == 1'b0) begin
                off = cyc - c0;
                break;
            end
        end
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // RDR read whose access phase ends on the edge c0+off.
    task automatic timed_rdr_read(input int c0, input int off);
        logic [31:0] d, e;
        while (cyc < c0 + off - 2) clk(1);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = 5'h04; PENABLE = 1'b0;
        clk(1);
        PENABLE = 1'b1;
        #1;
        d = PRDATA;
        e = (exp_q.size() > 0) ? {24'd0, exp_q.pop_front()} : 32'd0;
        check_eq("rdr_on_push_edge", d, e);
        clk(1);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        int c0, off;
        bit en, good;

        rx = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PRESET = 1'b1;
        model_reset();
        clk(3);
        check_eq("reset_pready", {31'd0, PREADY}, 32'd0);
        check_eq("reset_prdata", PRDATA, 32'd0);
        PRESET = 1'b0;
        clk(2);
        check_usr("reset_usr");
        apb_read(5'h08, d);
        check_eq("reset_ucr", d, 32'd0);
        read_rdr("empty_rdr");

        PSEL = 1'b1; PWRITE = 1'b0; PADDR = 5'h00; PENABLE = 1'b0;
        clk(1);
        check_eq("setup_pready", {31'd0, PREADY}, 32'd0);
        PENABLE = 1'b1;
        #1;
        check_eq("access_pready", {31'd0, PREADY}, 32'd1);
        clk(1);
        PSEL = 1'b0; PENABLE = 1'b0;

        apb_write(5'h0C, 32'hFFFF_FFFF);
        apb_read(5'h0C, d);
        check_eq("unmapped_read", d, 32'd0);
        apb_write(5'h08, 32'hFFFF_FFFE);
        apb_read(5'h08, d);
        check_eq("ucr_upper_bits", d, 32'd0);

        // Receiver disabled: nothing recorded.
        send_frame(8'h7E, 1'b1, -1);
        check_usr("disabled_usr");

        set_en(1'b1);
        apb_read(5'h08, d);
        check_eq("ucr_enabled", d, 32'd1);
        send_frame(8'h55, 1'b1, -1);
        check_usr("usr_after_55");
        read_rdr("rdr_55");
        check_usr("usr_after_55_read");

        // Overflow: fifth frame is dropped.
        for (int i = 1; i <= 5; i++) send_frame(8'hA0 + 8'(i), 1'b1, -1);
        check_usr("usr_overrun");
        for (int i = 0; i < 4; i++) read_rdr("rdr_overrun_seq");
        check_usr("usr_drained_ovr");
        write_usr(32'h4);
        check_usr("usr_ovr_cleared");

        // Framing error.
        send_frame(8'h3C, 1'b0, -1);
        check_usr("usr_frame_err");
        write_usr(32'h8);
        check_usr("usr_fe_cleared");

        // Short low glitch of 4 ticks is a false start.
        align4();
        rx = 1'b0;
        clk(16);
        rx = 1'b1;
        clk(200);
        check_usr("usr_glitch");

        // Reset in the middle of a frame, with a byte already queued.
        send_frame(8'h11, 1'b1, -1);
        check_usr("usr_before_reset");
        send_frame(8'h99, 1'b1, 3);
        check_usr("usr_after_midreset");
        apb_read(5'h08, d);
        check_eq("ucr_after_midreset", d, 32'd0);
        set_en(1'b1);
        send_frame(8'h42, 1'b1, -1);
        read_rdr("rdr_42");
        check_usr("usr_after_42");

        // Locate the push edge relative to frame start (tick phase is fixed
        // since the last reset and frames are aligned).
        align4();
        c0 = cyc;
        fork
            send_frame(8'h5A, 1'b1, -1);
            poll_push(c0, off);
        join
        check_eq("push_edge_found", {31'd0, off > 2}, 32'd1);
        read_rdr("rdr_5a");

        // Pop coinciding with a push into a full FIFO.
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, -1);
        check_usr("usr_full");
        if (off > 2) begin
            align4();
            c0 = cyc;
            fork
                send_frame(8'($urandom), 1'b1, -1);
                timed_rdr_read(c0, off);
            join
        end
        check_usr("usr_full_no_ovr");
        for (int i = 0; i < DEPTH; i++) read_rdr("rdr_after_simul");
        check_usr("usr_after_simul");

        // Random traffic.
        for (int it = 0; it < 10; it++) begin
            en = ($urandom_range(0, 5) != 0);
            set_en(en);
            b    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            send_frame(b, good, -1);
            check_usr("rand_usr");
            for (int r = $urandom_range(0, 3); r > 0; r--) read_rdr("rand_rdr");
            if ($urandom_range(0, 2) == 0) begin
                write_usr(32'hC);
                check_usr("rand_usr_w1c");
            end
        end
        while (exp_q.size() > 0) read_rdr("final_drain");
        check_usr("final_usr");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
